knight_decoder: RTL

//  Receive-side checker for the knight-rider LED scanner: samples the WIDTH-bit LED vector,

---
 rtl/knight_decoder_if.sv | 28 ++
 rtl/knight_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/knight_decoder_if.sv
// LED-bus bundle between a knight-rider scanner (master) and its decoder/checker (slave).
// The decoder builds without KNIGHT_DEC_SYNC_EN by default. Define that macro when led/led_stb must be synchronized into clk_in.
interface knight_decoder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned POS_W = $clog2(WIDTH);

  logic [WIDTH-1:0] led;
  logic             led_stb;
  logic             clr_cnt;
  logic             locked;
  logic             dir;
  logic [POS_W-1:0] pos;
  logic             err;
  logic [CNT_W-1:0] sweep_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output led, led_stb, clr_cnt,
    input  locked, dir, pos, err, sweep_cnt, err_cnt
  );

  modport slave (
    input  led, led_stb, clr_cnt,
    output locked, dir, pos, err, sweep_cnt, err_cnt
  );
endinterface

// File: rtl/knight_decoder.sv
// Receive-side checker for the knight-rider LED scanner: locks onto the sweep, reports head/dir,
// counts sweeps and violations. Define KNIGHT_DEC_SYNC_EN to add a 2-flop input synchronizer.
module knight_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  knight_decoder_if.slave   bus
);
  localparam int unsigned POS_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TOP_TWO  = {2'b11, {(WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ZERO,
    ST_LOCK
  } state_e;

  logic [WIDTH-1:0] led_s;
  logic             stb_s;

`ifdef KNIGHT_DEC_SYNC_EN
  logic [WIDTH-1:0] led_m_q, led_s_q;
  logic             stb_m_q, stb_s_q;

  // Two-stage synchronizer for an LED source outside the clk_in domain
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      led_m_q <= '0;
      led_s_q <= '0;
      stb_m_q <= 1'b0;
      stb_s_q <= 1'b0;
    end else begin
      led_m_q <= bus.led;
      led_s_q <= led_m_q;
      stb_m_q <= bus.led_stb;
      stb_s_q <= stb_m_q;
    end
  end

  assign led_s = led_s_q;
  assign stb_s = stb_s_q;
`else
  assign led_s = bus.led;
  assign stb_s = bus.led_stb;
`endif

  // Legal successor of frame p for the given sweep direction; MSB of result is the new dir
  function automatic logic [WIDTH:0] model_next(input logic [WIDTH-1:0] p, input logic up);
    logic [WIDTH-1:0] f;
    logic             d;
    d = up;
    if (up) begin
      if (p == '0)                             f = ONE;
      else if (p == ONE)                       f = WIDTH'(3);
      else if (p[WIDTH-1:WIDTH-2] == 2'b10) begin
        f = '0;
        d = 1'b0;
      end else                                 f = p << 1;
    end else begin
      if (p == '0)                             f = MSB_ONLY;
      else if (p[WIDTH-1:WIDTH-2] == 2'b10)    f = TOP_TWO;
      else if (p == ONE) begin
        f = '0;
        d = 1'b1;
      end else                                 f = p >> 1;
    end
    return {d, f};
  endfunction

  function automatic logic [POS_W-1:0] hi_idx(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[POS_W'(i)]) idx = POS_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [POS_W-1:0] lo_idx(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[POS_W'(WIDTH-1-i)]) idx = POS_W'(WIDTH-1-i);
    end
    return idx;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic [WIDTH:0]   nxt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HUNT;
      p_q      <= '0;
      dir_q    <= 1'b1;
      pos_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sweep_q  <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sweep_q  <= sweep_d;
      errc_q   <= errc_d;
    end
  end

  // Next-state and registered-output logic; nothing moves without a strobed frame
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    err_d   = 1'b0;
    sweep_d = sweep_q;
    errc_d  = errc_q;
    nxt     = model_next(p_q, dir_q);

    if (stb_s) begin
      unique case (state_q)
        ST_HUNT: begin
          if (led_s == '0) state_d = ST_ZERO;
        end
        ST_ZERO: begin
          if (led_s == ONE) begin
            state_d = ST_LOCK;
            dir_d   = 1'b1;
            p_d     = ONE;
            pos_d   = '0;
          end else if (led_s == MSB_ONLY) begin
            state_d = ST_LOCK;
            dir_d   = 1'b0;
            p_d     = MSB_ONLY;
            pos_d   = POS_W'(WIDTH-1);
          end else if (led_s != '0) begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCK: begin
          if (led_s == nxt[WIDTH-1:0]) begin
            p_d   = led_s;
            dir_d = nxt[WIDTH];
            if (nxt[WIDTH] != dir_q) sweep_d = sweep_q + CNT_W'(1);
            if (led_s != '0) pos_d = nxt[WIDTH] ? hi_idx(led_s) : lo_idx(led_s);
          end else begin
            // A zero mismatch also drops to HUNT so relock needs a fresh 0 frame
            err_d   = 1'b1;
            state_d = ST_HUNT;
            if (errc_q != '1) errc_d = errc_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (bus.clr_cnt) begin
      sweep_d = '0;
      errc_d  = '0;
    end

    locked_d = (state_d == ST_LOCK);
  end

  assign bus.locked    = locked_q;
  assign bus.dir       = dir_q;
  assign bus.pos       = pos_q;
  assign bus.err       = err_q;
  assign bus.sweep_cnt = sweep_q;
  assign bus.err_cnt   = errc_q;
endmodule
